// File: rtl/mul_writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_writeback_unit_if
//  Purpose  : Bundles the issue-side request and the register-file writeback
//             port of the shift-add multiplier.
//  Ports    : master - pipeline side (drives start/operands, sees results)
//             slave  - multiplier side (consumes request, drives writeback)
//             start, is_signed, flush, A_in, B_in, DA_in : request
//             busy, RW_out, MD_out, DA_out, D_out, err   : writeback / stall
//  Revision : 1.0 - initial release
// ============================================================================
interface mul_writeback_unit_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic                 start;
    logic                 is_signed;
    logic                 flush;
    logic [WIDTH-1:0]     A_in;
    logic [WIDTH-1:0]     B_in;
    logic [ADDR_W-1:0]    DA_in;
    logic                 busy;
    logic                 RW_out;
    logic [1:0]           MD_out;
    logic [ADDR_W-1:0]    DA_out;
    logic [2*WIDTH-1:0]   D_out;
    logic                 err;

    modport master (
        output start, is_signed, flush, A_in, B_in, DA_in,
        input  busy, RW_out, MD_out, DA_out, D_out, err
    );

    modport slave (
        input  start, is_signed, flush, A_in, B_in, DA_in,
        output busy, RW_out, MD_out, DA_out, D_out, err
    );
endinterface
`default_nettype wire

// File: rtl/mul_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_writeback_unit
//  Purpose  : Multi-cycle WIDTHxWIDTH shift-add multiplier that produces one
//             register-pair writeback beat (DA = low word, DA+1 = high word).
//  Ports    : clk    - system clock, rising edge
//             rst    - synchronous active-high reset
//             wb_if  - slave modport: request in, stall + writeback out
//  Timing   : accept at edge T, RUN on edges T+1..T+32, sign fix-up at T+33,
//             write beat visible for one cycle after T+33, idle after T+34.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_writeback_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    mul_writeback_unit_if.slave   wb_if
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [1:0]       MD_PAIR   = 2'b11;
    localparam logic [1:0]       MD_SINGLE = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PW-1:0]       mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [PW-1:0]       prod_q;
    logic                neg_q;
    logic [ADDR_W-1:0]   da_q;

    logic                busy_q;
    logic                rw_q;
    logic [1:0]          md_q;
    logic [ADDR_W-1:0]   da_out_q;
    logic [PW-1:0]       d_out_q;
    logic                err_q;

    // Magnitudes and result sign computed from the live request so they can
    // be captured in the accept cycle. The most negative value negates to
    // itself, which is the correct unsigned magnitude.
    logic [WIDTH-1:0]    a_abs_d;
    logic [WIDTH-1:0]    b_abs_d;
    logic                neg_d;
    logic [PW-1:0]       prod_add_d;
    logic [PW-1:0]       prod_fix_d;
    logic                wrap_d;

    always_comb begin
        a_abs_d = wb_if.A_in;
        b_abs_d = wb_if.B_in;
        neg_d   = 1'b0;
        if (wb_if.is_signed) begin
            if (wb_if.A_in[WIDTH-1]) a_abs_d = -wb_if.A_in;
            if (wb_if.B_in[WIDTH-1]) b_abs_d = -wb_if.B_in;
            neg_d = wb_if.A_in[WIDTH-1] ^ wb_if.B_in[WIDTH-1];
        end
    end

    always_comb begin
        prod_add_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        prod_fix_d = neg_q ? -prod_q : prod_q;
        // A pair write at the top register would wrap into R0.
        wrap_d     = &da_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            da_q     <= '0;
            busy_q   <= 1'b0;
            rw_q     <= 1'b0;
            md_q     <= MD_SINGLE;
            da_out_q <= '0;
            d_out_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // flush outranks start: nothing is accepted that cycle.
                    if (wb_if.start && !wb_if.flush) begin
                        da_q     <= wb_if.DA_in;
                        neg_q    <= neg_d;
                        mcand_q  <= {{WIDTH{1'b0}}, a_abs_d};
                        mplier_q <= b_abs_d;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (wb_if.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        prod_q   <= prod_add_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_ITER) begin
                            state_q <= S_FIXUP;
                        end
                    end
                end

                S_FIXUP: begin
                    if (wb_if.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        // Result registers load directly from the fix-up so
                        // the beat is visible in the WRITE cycle.
                        prod_q   <= prod_fix_d;
                        d_out_q  <= prod_fix_d;
                        da_out_q <= da_q;
                        rw_q     <= 1'b1;
                        md_q     <= wrap_d ? MD_SINGLE : MD_PAIR;
                        err_q    <= wrap_d;
                        state_q  <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    // start is ignored here; a held start is taken from IDLE.
                    rw_q    <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    rw_q    <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_if.busy   = busy_q;
    assign wb_if.RW_out = rw_q;
    assign wb_if.MD_out = md_q;
    assign wb_if.DA_out = da_out_q;
    assign wb_if.D_out  = d_out_q;
    assign wb_if.err    = err_q;

endmodule
`default_nettype wire
